// File: rtl/seq_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl_if
// Purpose : start/done handshake and operand/product bus between a requester
//           and the seq_mult_ctrl signed sequential multiplier.
// Signals :
//   i_start    request (requester -> multiplier)
//   i_a_in     signed multiplicand, N bits
//   i_b_in     signed multiplier, N bits
//   o_busy     multiplier working (LOAD, MULT, SIGN)
//   o_done     one-cycle completion pulse
//   o_product  signed 2N-bit product
// Modports: master = requester side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_mult_ctrl_if #(
    parameter int N = 10
);
    logic             i_start;
    logic [N-1:0]     i_a_in;
    logic [N-1:0]     i_b_in;
    logic             o_busy;
    logic             o_done;
    logic [2*N-1:0]   o_product;

    modport master (
        output i_start, i_a_in, i_b_in,
        input  o_busy, o_done, o_product
    );

    modport slave (
        input  i_start, i_a_in, i_b_in,
        output o_busy, o_done, o_product
    );
endinterface

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
// Purpose : signed sequential shift-add multiplier controller and datapath.
//           Operands are converted to magnitudes, multiplied with an unsigned
//           shift-add loop, and the 2N-bit result is negated if signs differ.
// Ports   :
//   i_clk   clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     seq_mult_ctrl_if.slave (start, a_in, b_in, busy, done, product)
// Build option:
//   EARLY_TERM_EN  when defined, MULT stops as soon as the remaining
//                  multiplier bits are all zero; otherwise exactly N iterations.
//
//   state  | meaning
//   IDLE   | waiting for start; operands latched on the accepting edge
//   LOAD   | magnitudes and result sign prepared, accumulator cleared
//   MULT   | one shift-add iteration per cycle
//   SIGN   | product register updated with signed result
//   DONE   | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
    parameter int N = 10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    seq_mult_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MULT = 3'd2;
    localparam logic [2:0] S_SIGN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]     r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_mult;
    logic [2*N-1:0] r_mcand;
    logic [2*N-1:0] r_acc;
    logic [2*N-1:0] r_product;
    logic           r_neg;

    logic [N-1:0]   w_mag_a;
    logic [N-1:0]   w_mag_b;
    logic           w_mult_last;

    // Magnitude as N-bit unsigned; the most negative value maps to 2^(N-1).
    function automatic logic [N-1:0] f_mag(input logic [N-1:0] x);
        return x[N-1] ? (~x + N'(1)) : x;
    endfunction

    assign w_mag_a = f_mag(r_a);
    assign w_mag_b = f_mag(r_b);

`ifdef EARLY_TERM_EN
    // Last iteration when the shifted multiplier will be zero.
    assign w_mult_last = (r_mult[N-1:1] == '0);
`else
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    logic [CW-1:0] r_cnt;

    // Remaining-iterations down-counter; terminal count marks the last one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_cnt <= CW'(N - 1);
        end else if ((r_state == S_MULT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign w_mult_last = (r_cnt == '0);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_mult    <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_neg     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_a     <= bus.i_a_in;
                        r_b     <= bus.i_b_in;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_mcand <= {{N{1'b0}}, w_mag_a};
                    r_mult  <= w_mag_b;
                    r_acc   <= '0;
                    // A zero operand must never yield a negated (all-ones+1) zero path.
                    r_neg   <= (r_a[N-1] ^ r_b[N-1]) && (r_a != '0) && (r_b != '0);
                    r_state <= S_MULT;
                end
                S_MULT: begin
                    if (r_mult[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand <= r_mcand << 1;
                    r_mult  <= r_mult >> 1;
                    if (w_mult_last) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    r_product <= r_neg ? (~r_acc + (2*N)'(1)) : r_acc;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy    = (r_state == S_LOAD) || (r_state == S_MULT) || (r_state == S_SIGN);
    assign bus.o_done    = (r_state == S_DONE);
    assign bus.o_product = r_product;

endmodule
